// File: rtl/residual_depacker.sv
// Reassembles four 32-bit FIFO words into one 128-bit residual block, then holds it on a valid/accept handshake.
// Optional build macro DEPACK_BYTE_SWAP_EN byte-reverses every captured word (big-endian host).
module residual_depacker #(
    parameter int BLOCKS_PER_FRAME = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         FIFO_rx_empty,
    output logic         FIFO_rx_enable,
    input  logic [31:0]  FIFO_rx_dout,
    output logic [127:0] data_flat,
    output logic         data_ready,
    input  logic         data_accept,
    output logic         frame_complete,
    output logic [15:0]  block_count
);

    localparam logic [15:0] LAST_BLK = 16'(BLOCKS_PER_FRAME - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_issued;
    logic [2:0]     r_captured;
    logic           r_rd_d1;
    logic [127:0]   r_data;
    logic           r_ready;
    logic           r_frame;
    logic [15:0]    r_blk;

    logic           w_rd;
    logic           w_cap;
    logic           w_last_word;
    logic           w_take;
    logic [6:0]     w_slot_lsb;

    function automatic logic [31:0] order_word(input logic [31:0] w);
`ifdef DEPACK_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always_comb begin
        // Strobe is held low through the reset cycle so nothing is popped that would be dropped.
        w_rd        = !rst && (r_state == S_FILL) && !FIFO_rx_empty && (r_issued < 3'd4);
        w_cap       = r_rd_d1;
        w_last_word = w_cap && (r_captured == 3'd3);
        w_take      = r_ready && data_accept;
        w_slot_lsb  = {r_captured[1:0], 5'b00000};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_last_word) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_take)      w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued   <= 3'd0;
            r_captured <= 3'd0;
            r_rd_d1    <= 1'b0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_frame    <= 1'b0;
            r_blk      <= 16'd0;
        end else begin
            r_rd_d1 <= w_rd;
            r_frame <= 1'b0;
            if (w_rd) begin
                r_issued <= r_issued + 3'd1;
            end
            if (w_cap) begin
                r_data[w_slot_lsb +: 32] <= order_word(FIFO_rx_dout);
                r_captured               <= r_captured + 3'd1;
            end
            if (w_last_word) begin
                r_ready <= 1'b1;
            end
            // No read is outstanding in HOLD, so acceptance never collides with a capture.
            if (w_take) begin
                r_ready    <= 1'b0;
                r_issued   <= 3'd0;
                r_captured <= 3'd0;
                if (r_blk == LAST_BLK) begin
                    r_blk   <= 16'd0;
                    r_frame <= 1'b1;
                end else begin
                    r_blk <= r_blk + 16'd1;
                end
            end
        end
    end

    assign FIFO_rx_enable = w_rd;
    assign data_flat      = r_data;
    assign data_ready     = r_ready;
    assign frame_complete = r_frame;
    assign block_count    = r_blk;

endmodule
